// File: rtl/mag_compare_serial.sv
// Bit-serial magnitude comparator, MSB first with early exit; result held on eq/gt/lt and steps.
// Latency: m+1 cycles from start to done (m = bits examined). start is ignored while busy, and accepted again in the DONE cycle.
module mag_compare_serial #(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                     CLK100MHZ,
    input  logic                     CPU_RESETN,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     eq,
    output logic                     gt,
    output logic                     lt,
    output logic [$clog2(WIDTH):0]   steps
);

    localparam int IW = $clog2(WIDTH);
    localparam int SW = IW + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic [SW-1:0]   steps_q, steps_d;

    logic bit_a, bit_b, sign_pos, a_wins;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        eq_d     = eq_q;
        gt_d     = gt_q;
        lt_d     = lt_q;
        steps_d  = steps_q;
        bit_a    = a_q[idx_q];
        bit_b    = b_q[idx_q];
        // In signed mode the sign bit carries negative weight, so a set bit there means smaller.
        sign_pos = SIGNED && (idx_q == IW'(WIDTH - 1));
        a_wins   = sign_pos ? bit_b : bit_a;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IW'(WIDTH - 1);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (bit_a != bit_b) begin
                    eq_d    = 1'b0;
                    gt_d    = a_wins;
                    lt_d    = !a_wins;
                    steps_d = SW'(WIDTH) - SW'(idx_q);
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    steps_d = SW'(WIDTH);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == SHIFT);
        done  = (state_q == DONE);
        eq    = eq_q;
        gt    = gt_q;
        lt    = lt_q;
        steps = steps_q;
    end

endmodule

// File: tb/tb_mag_compare_serial.sv
// Directed bench for mag_compare_serial, WIDTH=4, with one unsigned and one signed instance.
module tb_mag_compare_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a, b;
    logic       start_u, start_s;
    logic       busy_u, done_u, eq_u, gt_u, lt_u;
    logic       busy_s, done_s, eq_s, gt_s, lt_s;
    logic [2:0] steps_u, steps_s;
    logic [7:0] ou, os;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mag_compare_serial #(.WIDTH(4), .SIGNED(1'b0)) u_uns (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .a(a), .b(b), .start(start_u),
        .busy(busy_u), .done(done_u), .eq(eq_u), .gt(gt_u), .lt(lt_u), .steps(steps_u)
    );

    mag_compare_serial #(.WIDTH(4), .SIGNED(1'b1)) u_sgn (
        .CLK100MHZ(clk), .CPU_RESETN(rst_n), .a(a), .b(b), .start(start_s),
        .busy(busy_s), .done(done_s), .eq(eq_s), .gt(gt_s), .lt(lt_s), .steps(steps_s)
    );

    // {busy, done, eq, gt, lt, steps[2:0]}
    assign ou = {busy_u, done_u, eq_u, gt_u, lt_u, steps_u};
    assign os = {busy_s, done_s, eq_s, gt_s, lt_s, steps_s};

    task automatic run_cmp(input bit sel, input logic [3:0] ta, input logic [3:0] tb_v,
                           input logic [2:0] exp_res, input int exp_steps, input string name);
        int cyc = 0;
        logic [7:0] o;
        @(negedge clk);
        a = ta; b = tb_v;
        if (sel) start_s = 1'b1; else start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0; start_s = 1'b0;
        o = sel ? os : ou;
        while (o[7] && cyc < 20) begin
            cyc++;
            @(negedge clk);
            o = sel ? os : ou;
        end
        nvec++;
        if (cyc !== exp_steps) begin
            nerr++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, cyc, exp_steps);
        end
        nvec++;
        if (o[6] !== 1'b1) begin
            nerr++; $display("FAIL %s done: got %b expected 1", name, o[6]);
        end
        nvec++;
        if (o[5:3] !== exp_res) begin
            nerr++; $display("FAIL %s eq_gt_lt: got %b expected %b", name, o[5:3], exp_res);
        end
        nvec++;
        if (o[2:0] !== 3'(exp_steps)) begin
            nerr++; $display("FAIL %s steps: got %0d expected %0d", name, o[2:0], exp_steps);
        end
        @(negedge clk);
        o = sel ? os : ou;
        nvec++;
        if (o[6] !== 1'b0) begin
            nerr++; $display("FAIL %s done_width: got %b expected 0", name, o[6]);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_u = 1'b0; start_s = 1'b0; a = 4'hF; b = 4'h0;
        repeat (3) @(negedge clk);
        nvec++;
        if (ou !== 8'h00) begin
            nerr++; $display("FAIL reset_uns: got %h expected 00", ou);
        end
        nvec++;
        if (os !== 8'h00) begin
            nerr++; $display("FAIL reset_sgn: got %h expected 00", os);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        run_cmp(1'b0, 4'b1011, 4'b0111, 3'b010, 1, "uns_gt_msb");
        run_cmp(1'b0, 4'b0110, 4'b0111, 3'b001, 4, "uns_lt_lsb");
        run_cmp(1'b0, 4'b0101, 4'b0101, 3'b100, 4, "uns_eq");
        run_cmp(1'b0, 4'b1001, 4'b1010, 3'b001, 3, "uns_lt_mid");
    endtask

    task automatic test_signed;
        run_cmp(1'b1, 4'b1111, 4'b0001, 3'b001, 1, "sgn_neg_vs_pos");
        run_cmp(1'b1, 4'b1000, 4'b1001, 3'b001, 4, "sgn_m8_vs_m7");
        run_cmp(1'b1, 4'b0111, 4'b1000, 3'b010, 1, "sgn_max_vs_min");
        run_cmp(1'b1, 4'b1010, 4'b1010, 3'b100, 4, "sgn_eq");
    endtask

    task automatic test_hold;
        run_cmp(1'b0, 4'b1100, 4'b1000, 3'b010, 2, "hold_setup");
        repeat (3) @(negedge clk);
        nvec++;
        if (ou !== {2'b00, 3'b010, 3'd2}) begin
            nerr++; $display("FAIL hold_idle: got %h expected %h", ou, {2'b00, 3'b010, 3'd2});
        end
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        @(negedge clk);
        a = 4'd3; b = 4'd3; start_u = 1'b1;
        @(negedge clk);
        a = 4'd9; b = 4'd2;
        while (ou[7] && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        nvec++;
        if ({cyc[3:0], ou[6:0]} !== {4'd4, 1'b1, 3'b100, 3'd4}) begin
            nerr++; $display("FAIL b2b_first: got cyc=%0d out=%h expected cyc=4 out=%h", cyc, ou, {2'b01, 3'b100, 3'd4});
        end
        @(negedge clk);
        nvec++;
        if (ou !== {2'b10, 3'b100, 3'd4}) begin
            nerr++; $display("FAIL b2b_second_shift: got %h expected %h", ou, {2'b10, 3'b100, 3'd4});
        end
        @(negedge clk);
        start_u = 1'b0;
        nvec++;
        if (ou !== {2'b01, 3'b010, 3'd1}) begin
            nerr++; $display("FAIL b2b_second_result: got %h expected %h", ou, {2'b01, 3'b010, 3'd1});
        end
        @(negedge clk);
        nvec++;
        if (ou[7:6] !== 2'b00) begin
            nerr++; $display("FAIL b2b_done_width: got busy,done=%b expected 00", ou[7:6]);
        end
    endtask

    task automatic test_start_ignored;
        int ndone = 0;
        logic [5:0] res = '0;
        @(negedge clk);
        a = 4'b0110; b = 4'b0111; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0; a = 4'b1111; b = 4'b0000;
        @(negedge clk);
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (ou[6]) begin
                ndone++;
                res = ou[5:0];
            end
            @(negedge clk);
        end
        nvec++;
        if (ndone !== 1) begin
            nerr++; $display("FAIL ign_done_count: got %0d expected 1", ndone);
        end
        nvec++;
        if (res !== {3'b001, 3'd4}) begin
            nerr++; $display("FAIL ign_result: got %h expected %h", res, {3'b001, 3'd4});
        end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        @(negedge clk);
        a = 4'b0110; b = 4'b0111; start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if (ou !== 8'h00) begin
            nerr++; $display("FAIL rst_mid_async: got %h expected 00", ou);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ou[6]) ndone++;
            @(negedge clk);
        end
        nvec++;
        if (ndone !== 0) begin
            nerr++; $display("FAIL rst_mid_done: got %0d pulses expected 0", ndone);
        end
        run_cmp(1'b0, 4'b0101, 4'b0011, 3'b010, 2, "rst_mid_restart");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_hold();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mag_compare_serial.md
# mag_compare_serial

Parametrised, sequential magnitude comparator for the lab board. It compares two WIDTH-bit operands one bit per clock, starting at the MSB, and stops as soon as the operands differ. A start/busy/done handshake controls each comparison, and the result is held on three RGB LED lines until the next comparison completes. It supersedes the fixed 2-bit combinational comparator by adding operand width, a signed mode, early termination and a step count.

## Interface
- WIDTH, 4: operand width in bits; legal range is WIDTH ≥ 2.
- SIGNED, 0: 0 compares the operands as unsigned; 1 compares them as two's complement.
- CLK100MHZ  in  1  system clock; all state changes on its rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A; sampled only when a start is accepted.
- b  in  WIDTH  operand B; sampled only when a start is accepted.
- start  in  1  request a comparison; level-sampled on the clock edge.
- busy  out  1  high while a comparison is in progress (SHIFT state).
- done  out  1  one-cycle pulse marking that the result lines have just been updated.
- eq  out  1  A == B; drives LED16_R.
- gt  out  1  A > B; drives LED16_B.
- lt  out  1  A < B; drives LED16_G.
- steps  out  $clog2(WIDTH)+1  number of bit positions examined by the last comparison (1..WIDTH).

## Operation
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low: assertion takes effect immediately, without waiting for a clock edge.
- Reset values:
  - State = IDLE.
  - busy = done = eq = gt = lt = 0 (all LEDs off).
  - steps = 0.
  - Internal shift registers and index cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If start = 1: capture a and b into internal registers, set index = WIDTH-1, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, on each edge, compare captured bits A[index] and B[index]:
  - Bits differ: decide the result and go to DONE.
    - Unsigned, or signed with index < WIDTH-1: A bit 1 → gt = 1; B bit 1 → lt = 1.
    - Signed with index = WIDTH-1 (sign bit): A bit 1 → lt = 1; B bit 1 → gt = 1.
  - Bits equal and index = 0: eq = 1, go to DONE.
  - Bits equal and index > 0: decrement index, stay in SHIFT.
  - On every decision edge:
    - Exactly one of eq/gt/lt becomes 1; the other two are cleared.
    - steps is loaded with WIDTH - index.
- DONE:
  - done = 1 for this one cycle.
  - If start = 1: capture new operands and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- Start handling:
  - start is ignored while in SHIFT; the operands captured at acceptance are not disturbed.
  - Changes on a and b after capture have no effect on the comparison in progress.
- Result hold: eq/gt/lt and steps keep their values through IDLE and through the next SHIFT, and change only on the next decision edge.
- Reset during SHIFT: the comparison is abandoned, all outputs return to their reset values, and no done pulse is produced.

## Timing
- Latency:
  - Start accepted at edge E0; m = number of bits examined (m = WIDTH for equal operands).
  - The decision is registered at edge Em.
  - eq/gt/lt, steps and done are all valid from Em until Em+1; done falls at Em+1.
- busy:
  - High from E0 to Em, i.e. exactly m cycles.
  - Low during the DONE cycle.
- Throughput:
  - Back-to-back period is m+1 cycles, with start held high through DONE.
  - Worst case is WIDTH+1 cycles per comparison.
- All outputs are registered; none is a combinational path from the inputs.

## Test plan
- WIDTH=4, SIGNED=0, a=1011, b=0111, start pulsed 1 cycle: busy high for 1 cycle, then done=1 with gt=1, eq=lt=0, steps=1.
- WIDTH=4, SIGNED=0, a=0110, b=0111: busy high for 4 cycles, then done with lt=1, steps=4; with a=b=0101, done with eq=1, steps=4.
- WIDTH=4, SIGNED=1, a=1111 (-1), b=0001: lt=1, steps=1. Then a=1000 (-8), b=1001 (-7): lt=1, steps=4.
- Start held high continuously with a=3, b=3, and the operands changed to a=9, b=2 (unsigned) while in SHIFT: the first result is eq, steps=4. The second comparison is accepted in the DONE cycle using a=9, b=2 and gives gt, steps=1. done is never high for more than one cycle.
- start re-pulsed during SHIFT: ignored; exactly one done pulse occurs for the original operands.
- CPU_RESETN driven low asynchronously (between edges) in the second SHIFT cycle: all outputs go to 0 immediately with no done pulse; after release, IDLE accepts a new start normally.
